// File: rtl/ohm_pkg.sv
// Shared types and constants for the ohm one-hot arbiter: FSM states, the
// default sizing, and the rotating-priority winner search.
package ohm_pkg;

  localparam int OHM_NUM_REQ  = 4;
  localparam int OHM_MAX_HOLD = 8;
  localparam int MAX_REQ      = 32;

  typedef enum logic {IDLE, GRANT} state_t;

  typedef struct packed {
    logic       found;
    logic [7:0] idx;
  } win_t;

  // First set bit of req at or above ptr, wrapping at n.
  function automatic win_t find_winner(input logic [MAX_REQ-1:0] req,
                                       input logic [7:0] ptr,
                                       input int n);
    win_t w;
    int   j;
    w = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        j = int'(ptr) + i;
        if (j >= n) j = j - n;
        if (!w.found && req[j[4:0]]) begin
          w.found = 1'b1;
          w.idx   = 8'(j);
        end
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/ohm.sv
// One-hot AND-OR multiplexer: y is the bit of a picked by the one-hot sel.
module ohm #(
  parameter int N = 4
) (
  input  logic [N-1:0] sel,
  input  logic [N-1:0] a,
  output logic         y
);

  assign y = |(sel & a);

endmodule

// File: rtl/ohm_arb.sv
// Rotating-priority arbiter with bounded hold time and a registered one-hot
// grant that steers one requester's data bit through the ohm mux.
module ohm_arb
  import ohm_pkg::*;
#(
  parameter int NUM_REQ  = OHM_NUM_REQ,
  parameter int MAX_HOLD = OHM_MAX_HOLD
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         a_i,
  output logic [NUM_REQ-1:0]         sel_o,
  output logic                       gnt_valid_o,
  output logic                       y_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o
);

  localparam int         OW       = $clog2(NUM_REQ);
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  sel_q, sel_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       ptr_q, ptr_d;
  logic [7:0]          hold_q, hold_d;
  logic [NUM_REQ-1:0]  others;
  logic [OW-1:0]       nptr;
  win_t                win;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    others  = req_i & ~sel_q;
    nptr    = ptr_q;
    win     = '0;
    case (state_q)
      IDLE: begin
        win = find_winner(MAX_REQ'(req_i), 8'(ptr_q), NUM_REQ);
        if (win.found) begin
          state_d = GRANT;
          sel_d   = NUM_REQ'(1) << win.idx;
          owner_d = OW'(win.idx);
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!req_i[owner_q] || (hold_q == HOLD_MAX && |others)) begin
          // Release: the next owner is chosen in the same edge, old owner masked.
          nptr  = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);
          ptr_d = nptr;
          win   = find_winner(MAX_REQ'(others), 8'(nptr), NUM_REQ);
          hold_d = '0;
          if (win.found) begin
            sel_d   = NUM_REQ'(1) << win.idx;
            owner_d = OW'(win.idx);
          end else begin
            state_d = IDLE;
            sel_d   = '0;
            owner_d = '0;
          end
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign sel_o       = sel_q;
  assign gnt_valid_o = |sel_q;
  assign owner_o     = owner_q;

  ohm #(.N(NUM_REQ)) u_mux (
    .sel (sel_q),
    .a   (a_i),
    .y   (y_o)
  );

endmodule

// File: tb/tb_ohm_arb.sv
// Directed bench for ohm_arb: the driver queues hand-computed grants per
// edge and a negedge monitor pops and compares them.
module tb_ohm_arb;

  logic       clk;
  logic       reset_n;
  logic [3:0] req_i;
  logic [3:0] a_i;
  logic [3:0] sel_o;
  logic       gnt_valid_o;
  logic       y_o;
  logic [1:0] owner_o;

  typedef struct {
    logic [3:0] sel;
    logic [1:0] own;
    logic       y;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  ohm_arb #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_i       (req_i),
    .a_i         (a_i),
    .sel_o       (sel_o),
    .gnt_valid_o (gnt_valid_o),
    .y_o         (y_o),
    .owner_o     (owner_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // One clock of stimulus; es/eo is the grant expected after this edge.
  task automatic cyc(input logic [3:0] r, input logic [3:0] a,
                     input logic [3:0] es, input logic [1:0] eo);
    exp_t e;
    req_i = r;
    a_i   = a;
    @(posedge clk);
    e.sel = es;
    e.own = eo;
    e.y   = |(es & a);
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    reset_n = 1'b0;
    #1;
    chk("rst_sel", 32'(sel_o), 32'h0);
    chk("rst_valid", 32'(gnt_valid_o), 32'h0);
    chk("rst_owner", 32'(owner_o), 32'h0);
    chk("rst_y", 32'(y_o), 32'h0);
    #1;
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1) begin
      chk("onehot0", 32'($onehot0(sel_o)), 32'h1);
      chk("valid_eq_or", 32'(gnt_valid_o), 32'(|sel_o));
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("sel", 32'(sel_o), 32'(e.sel));
      chk("owner", 32'(owner_o), 32'(e.own));
      chk("y", 32'(y_o), 32'(e.y));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    req_i   = '0;
    a_i     = '0;
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_sel", 32'(sel_o), 32'h0);
    chk("reset_valid", 32'(gnt_valid_o), 32'h0);
    chk("reset_owner", 32'(owner_o), 32'h0);
    chk("reset_y", 32'(y_o), 32'h0);
    reset_n = 1'b1;

    cyc(4'b0000, 4'b1111, 4'b0000, 2'd0);
    cyc(4'b0000, 4'b1111, 4'b0000, 2'd0);

    // Sole requester 2 keeps the grant well past MAX_HOLD.
    for (int k = 0; k < 20; k++) cyc(4'b0100, 4'b0100, 4'b0100, 2'd2);
    // Saturated hold plus a new request forces rotation at once.
    cyc(4'b0101, 4'b0100, 4'b0001, 2'd0);
    cyc(4'b0000, 4'b0100, 4'b0000, 2'd0);
    rst_pulse();

    // All four requesting: 8 cycles each, no gap between grants.
    for (int k = 0; k < 40; k++)
      cyc(4'b1111, 4'b1010, 4'(1 << ((k / 8) % 4)), 2'((k / 8) % 4));
    cyc(4'b1111, 4'b1010, 4'b0010, 2'd1);

    // Owner 1 drops: search resumes at 2, lands on 3; then back to 0.
    cyc(4'b1001, 4'b1010, 4'b1000, 2'd3);
    cyc(4'b1001, 4'b1010, 4'b1000, 2'd3);
    cyc(4'b1001, 4'b1010, 4'b1000, 2'd3);
    cyc(4'b0001, 4'b1010, 4'b0001, 2'd0);
    cyc(4'b0000, 4'b1010, 4'b0000, 2'd0);

    // Data steering with a = 1010.
    cyc(4'b1000, 4'b1010, 4'b1000, 2'd3);
    cyc(4'b0100, 4'b1010, 4'b0100, 2'd2);
    cyc(4'b0010, 4'b1010, 4'b0010, 2'd1);
    cyc(4'b0001, 4'b1010, 4'b0001, 2'd0);
    cyc(4'b0000, 4'b1010, 4'b0000, 2'd0);

    // Pointer is 1 here; grant 2, then 3 to push the pointer to 3.
    cyc(4'b0100, 4'b1111, 4'b0100, 2'd2);
    cyc(4'b0100, 4'b1111, 4'b0100, 2'd2);
    a_i = 4'b0000;
    #1;
    chk("y_comb", 32'(y_o), 32'h0);
    cyc(4'b1000, 4'b1111, 4'b1000, 2'd3);

    // Reset mid-grant; next arbitration must start from pointer 0.
    rst_pulse();
    cyc(4'b1010, 4'b1111, 4'b0010, 2'd1);
    cyc(4'b1010, 4'b1111, 4'b0010, 2'd1);
    rst_pulse();
    cyc(4'b1000, 4'b1111, 4'b1000, 2'd3);
    cyc(4'b1000, 4'b1111, 4'b1000, 2'd3);
    cyc(4'b0000, 4'b1111, 4'b0000, 2'd0);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ohm_arb.md
OHM_ARB -- requirements
Module: ohm_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, which is also the one-hot select width.
REQ-002 Parameter MAX_HOLD, default 8: maximum cycles one owner keeps the grant while another requester is pending; legal range 2..255.
REQ-003 Port clk  input  1  sole clock, rising edge.
REQ-004 Port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port req_i  input  NUM_REQ  level requests, bit i = requester i.
REQ-006 Port a_i  input  NUM_REQ  data bits, bit i = requester i's data.
REQ-007 Port sel_o  output  NUM_REQ  registered one-hot grant/select, all-zero when idle.
REQ-008 Port gnt_valid_o  output  1  high when sel_o is non-zero.
REQ-009 Port y_o  output  1  a_i bit selected by sel_o; 0 when sel_o is zero.
REQ-010 Port owner_o  output  $clog2(NUM_REQ)  index of current owner, 0 when idle.

Function
REQ-011 The FSM SHALL have two states: IDLE and GRANT.
REQ-012 In IDLE with req_i nonzero at a rising edge, the block SHALL enter GRANT at that edge and drive the winner onto sel_o (1-cycle latency from request to grant).
REQ-013 The winner SHALL be the first set req_i bit, searching upward from rotating pointer ptr with wrap (ptr, ptr+1, ..., NUM_REQ-1, 0, ...).
REQ-014 In IDLE with req_i zero, the block SHALL stay in IDLE with sel_o = 0.
REQ-015 In GRANT, the owner SHALL keep the grant while req_i[owner] = 1, unless the forced-rotation rule applies.
REQ-016 hold_cnt SHALL clear to 0 on every new grant and increment each GRANT cycle, saturating at MAX_HOLD-1.
REQ-017 Forced rotation: at an edge where hold_cnt = MAX_HOLD-1 and any other req_i bit is set, the owner SHALL lose the grant.
REQ-018 Release: at an edge where req_i[owner] = 0 or forced rotation applies, ptr SHALL become (owner+1) mod NUM_REQ.
REQ-019 At a release edge, sel_o SHALL switch directly to the next winner, searched from the new ptr over req_i with the old owner's bit masked; there SHALL be no idle cycle between grants.
REQ-020 At a release edge with no remaining request, the block SHALL return to IDLE and set sel_o = 0.
REQ-021 A sole requester holding past MAX_HOLD SHALL keep the grant indefinitely; hold_cnt SHALL stay saturated.
REQ-022 sel_o SHALL never have more than one bit set.
REQ-023 y_o SHALL be combinational from sel_o and a_i, selecting a_i[owner] with zero latency.
REQ-024 A request dropped and reasserted within the same cycle SHALL not be distinguishable and SHALL be treated as continuous.

Reset
REQ-025 While reset_n = 0, the block SHALL asynchronously force state = IDLE, sel_o = 0, gnt_valid_o = 0, owner_o = 0, ptr = 0, and hold_cnt = 0; y_o SHALL be 0.
REQ-026 Reset asserted mid-grant SHALL drop the grant immediately, without waiting for a clock edge.
REQ-027 After deassertion, the first rising edge SHALL arbitrate from ptr = 0.

Structure
REQ-028 Package ohm_pkg SHALL hold the FSM state enum (IDLE, GRANT) and the default NUM_REQ and MAX_HOLD constants.
REQ-029 Data selection SHALL use one sub-module instance of the existing one-hot mux ohm, with sel = sel_o, a = a_i, and y_o taken from its AND-OR output.
REQ-030 Winner search SHALL be a function in ohm_pkg and SHALL contain no additional registers.

Verification
REQ-031 Scenario: reset, then req_i = 4'b0100 held → sel_o = 4'b0100 one cycle later, owner_o = 2, hold_cnt saturating at 7, grant kept.
REQ-032 Scenario: req_i = 4'b1111 after reset → sel_o sequence 0001, 0010, 0100, 1000, 0001, each held 8 cycles, no zero cycle between grants.
REQ-033 Scenario: owner 1 drops its request with req_i = 4'b1001 → next edge sel_o = 4'b1000 (search starts at 2), then grant returns to 0 after release.
REQ-034 Scenario: a_i = 4'b1010 while sel_o steps 1000, 0100, 0010, 0001 → y_o = 1, 0, 1, 0; sel_o = 0 → y_o = 0.
REQ-035 Scenario: reset_n pulsed low mid-grant between edges → sel_o = 0 immediately; after release with req_i = 4'b1000 → grant 1000 on the first edge, ptr = 0.
REQ-036 Checker: sel_o is one-hot-or-zero every cycle, and gnt_valid_o equals |sel_o.
